incr_pulse_gen: RTL and testbench

- Upstream stage of the counter: turns a raw, bouncy, asynchronous push-button level into clean single-cycle increment pulses.
- Pipeline: synchronizer, then debouncer, then press/auto-repeat state machine.
- Output incr_out drives the counter's incr_in directly; each high cycle of incr_out equals exactly one count.

---
 rtl/incr_pulse_gen_pkg.sv | 25 ++
 rtl/incr_pulse_gen_if.sv | 27 ++
 rtl/incr_pulse_gen_debounce.sv | 71 +++++++
 rtl/incr_pulse_gen.sv | 111 +++++++++++
 tb/tb_incr_pulse_gen.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/incr_pulse_gen_pkg.sv
// Shared types and default constants for the push-button increment pulse generator.
`timescale 1ns/1ps

package incr_pulse_pkg;

  // Press / auto-repeat state machine states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } pulse_state_e;

  // Default tuning of the pipeline
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_PERIOD   = 4;
  localparam int DEF_REPEAT_EN       = 1;

  // Larger of two integers, used to size the shared repeat timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/incr_pulse_gen_if.sv
// Button-side and counter-side signals of the increment pulse generator.
`timescale 1ns/1ps

interface incr_pulse_gen_if;

  logic btn_in;
  logic enable_in;
  logic incr_out;
  logic stable_out;

  // The driver of the button and enable, observer of the pulses
  modport master (
    output btn_in,
    output enable_in,
    input  incr_out,
    input  stable_out
  );

  // The pulse generator itself
  modport slave (
    input  btn_in,
    input  enable_in,
    output incr_out,
    output stable_out
  );

endinterface

// File: rtl/incr_pulse_gen_debounce.sv
// Synchronizer chain plus debounce counter for a raw push-button level.
// level_out is the debounce decision; stable_out is the same level one
// flop later, so the press state machine can see the 0->1 / 1->0 change
// as (level_out != stable_out) and emit its registered pulse on the very
// edge where stable_out itself moves.
`timescale 1ns/1ps

module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level_out,
  output logic stable_out
);

  localparam int CHAIN_W = SYNC_STAGES - 1;
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic               sync_q, sync_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               stable_q, stable_d;

  // Shift the raw level through the synchronizer; the last stage is sync_q
  always_comb begin
    chain_d    = chain_q << 1;
    chain_d[0] = btn_in;
    sync_d     = chain_q[CHAIN_W-1];
  end

  // Count consecutive disagreeing samples and flip the level once enough have been seen
  always_comb begin
    cnt_d    = '0;
    level_d  = level_q;
    stable_d = level_q;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers for synchronizer, counter and debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q  <= '0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      stable_q <= stable_d;
    end
  end

  assign level_out  = level_q;
  assign stable_out = stable_q;

endmodule

// File: rtl/incr_pulse_gen.sv
// Turns a bouncy asynchronous push-button into single-cycle increment pulses:
// one pulse per press, then auto-repeat pulses while the button is held.
`timescale 1ns/1ps

module incr_pulse_gen
  import incr_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic             clk,
  input  logic             rst,
  incr_pulse_gen_if.slave  bus
);

  localparam int TMR_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);
  localparam bit REPEAT_ON = (REPEAT_EN != 0);

  logic         level_w;
  logic         stable_w;
  logic         press_w;
  logic         release_w;
  logic         pulse;

  pulse_state_e state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic         incr_q, incr_d;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (bus.btn_in),
    .level_out  (level_w),
    .stable_out (stable_w)
  );

  // The debounced level is about to rise or fall on this edge
  assign press_w   = level_w & ~stable_w;
  assign release_w = ~level_w & stable_w;

  // Press / delay / repeat decisions; a release always wins over a pulse due on the same edge
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse   = 1'b0;
    if (release_w) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_w) begin
            pulse   = 1'b1;
            timer_d = DELAY_LOAD;
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (timer_q == '0) begin
            if (REPEAT_ON) begin
              pulse   = 1'b1;
              timer_d = PERIOD_LOAD;
              state_d = REPEAT;
            end
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        REPEAT: begin
          if (timer_q == '0) begin
            pulse   = 1'b1;
            timer_d = PERIOD_LOAD;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
    incr_d = pulse & bus.enable_in;
  end

  // FSM, repeat timer and the registered increment pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      incr_q  <= incr_d;
    end
  end

  assign bus.incr_out   = incr_q;
  assign bus.stable_out = stable_w;

endmodule

// File: tb/tb_incr_pulse_gen.sv
// Scoreboard bench for incr_pulse_gen: expected pulse edges and stable_out
// levels are queued as each scenario is driven and checked at every falling edge.
`timescale 1ns/1ps

module tb_incr_pulse_gen;

  localparam int LATENCY    = 6;
  localparam int REP_DELAY  = 16;
  localparam int REP_PERIOD = 4;

  typedef struct {
    int   edge_num;
    logic level;
  } stable_exp_t;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic btn_drv = 1'b1;
  logic en_drv  = 1'b1;

  int  edge_count   = 0;
  int  assert_count = 0;
  int  fail_count   = 0;
  int  pulse_count  = 0;
  bit  sb_on        = 1'b0;
  bit  pulse_due;
  stable_exp_t st_front;

  int          pulse_q[$];
  stable_exp_t stable_q[$];

  incr_pulse_gen_if bus();

  assign bus.btn_in    = btn_drv;
  assign bus.enable_in = en_drv;

  incr_pulse_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Number of rising edges seen so far; read only on falling edges
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pushStable(input int edge_num, input logic level);
    stable_exp_t e;
    e.edge_num = edge_num;
    e.level    = level;
    stable_q.push_back(e);
  endtask

  // Queue the pulses and stable_out levels for a clean hold whose first high
  // sample is at first_sample and which lasts hold_len samples.
  task automatic pushHold(input int first_sample, input int hold_len, input int mask_lo,
                          input int mask_hi, input bit with_release);
    int rise_edge;
    int off;
    rise_edge = first_sample + LATENCY;
    off = 0;
    while (off < hold_len) begin
      if (!(off >= mask_lo && off <= mask_hi)) pulse_q.push_back(rise_edge + off);
      off = (off == 0) ? REP_DELAY : off + REP_PERIOD;
    end
    pushStable(rise_edge - 1, 1'b0);
    pushStable(rise_edge, 1'b1);
    pushStable(rise_edge + hold_len / 2, 1'b1);
    if (with_release) begin
      pushStable(rise_edge + hold_len - 1, 1'b1);
      pushStable(rise_edge + hold_len, 1'b0);
    end
  endtask

  // Drive one button/enable level for a number of cycles, starting at a falling edge
  task automatic applyStimulus(input logic btn, input logic en, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      btn_drv = btn;
      en_drv  = en;
      @(negedge clk);
    end
  endtask

  // Scoreboard: compare pulses and queued stable_out levels each falling edge
  always @(negedge clk) begin
    if (sb_on) begin
      pulse_due = (pulse_q.size() > 0) && (pulse_q[0] == edge_count);
      if (pulse_due) void'(pulse_q.pop_front());
      if (pulse_due || bus.incr_out !== 1'b0)
        checkOutput($sformatf("incr_out@%0d", edge_count), 32'(bus.incr_out), 32'(pulse_due));
      if (bus.incr_out === 1'b1) pulse_count++;
      while (stable_q.size() > 0 && stable_q[0].edge_num <= edge_count) begin
        st_front = stable_q.pop_front();
        checkOutput($sformatf("stable_out@%0d", st_front.edge_num), 32'(bus.stable_out),
                    32'(st_front.level));
      end
    end
  end

  initial begin
    int s;
    int base;

    // Reset asserted with the button held: outputs clear without a clock
    #3 rst = 1'b1;
    #1;
    checkOutput("reset_incr_out", 32'(bus.incr_out), 32'd0);
    checkOutput("reset_stable_out", 32'(bus.stable_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("in_reset_incr_out", 32'(bus.incr_out), 32'd0);
      checkOutput("in_reset_stable_out", 32'(bus.stable_out), 32'd0);
    end
    btn_drv = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    sb_on = 1'b1;
    applyStimulus(1'b0, 1'b1, 8);

    // Clean press of 10 cycles: one pulse
    base = pulse_count;
    s = edge_count + 1;
    pushHold(s, 10, -1, -1, 1'b1);
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b0, 1'b1, 24);
    checkOutput("clean_press_count", 32'(pulse_count - base), 32'd1);

    // Bounce: 12 cycles toggling every 2 cycles, then 20 cycles high.
    // A 20-cycle hold also reaches the first auto-repeat at offset 16.
    base = pulse_count;
    s = edge_count + 1;
    for (int i = LATENCY; i < 12 + LATENCY; i++) pushStable(s + i, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2);
      applyStimulus(1'b0, 1'b1, 2);
    end
    pushHold(edge_count + 1, 20, -1, -1, 1'b1);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b0, 1'b1, 24);
    checkOutput("bounce_count", 32'(pulse_count - base), 32'd2);

    // Auto-repeat over a 40-cycle hold
    base = pulse_count;
    s = edge_count + 1;
    pushHold(s, 40, -1, -1, 1'b1);
    applyStimulus(1'b1, 1'b1, 40);
    applyStimulus(1'b0, 1'b1, 24);
    checkOutput("auto_repeat_count", 32'(pulse_count - base), 32'd7);

    // Enable masked for offsets 10..25 of a 40-cycle hold
    base = pulse_count;
    s = edge_count + 1;
    pushHold(s, 40, 10, 25, 1'b1);
    applyStimulus(1'b1, 1'b1, 16);
    applyStimulus(1'b1, 1'b0, 16);
    applyStimulus(1'b1, 1'b1, 8);
    applyStimulus(1'b0, 1'b1, 24);
    checkOutput("enable_mask_count", 32'(pulse_count - base), 32'd4);

    // Reset pulse of 20 ns at offset 18 of a hold
    base = pulse_count;
    s = edge_count + 1;
    pushHold(s, 17, -1, -1, 1'b0);
    applyStimulus(1'b1, 1'b1, 24);
    checkOutput("pre_reset_count", 32'(pulse_count - base), 32'd2);
    #2 rst = 1'b1;
    sb_on = 1'b0;
    pulse_q.delete();
    stable_q.delete();
    #1;
    checkOutput("midhold_reset_incr_out", 32'(bus.incr_out), 32'd0);
    checkOutput("midhold_reset_stable_out", 32'(bus.stable_out), 32'd0);
    #9;
    checkOutput("midhold_in_reset_stable_out", 32'(bus.stable_out), 32'd0);
    #10 rst = 1'b0;
    base = pulse_count;
    s = edge_count + 1;
    sb_on = 1'b1;
    pushHold(s, 18, -1, -1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 17);
    applyStimulus(1'b0, 1'b1, 30);
    checkOutput("post_reset_count", 32'(pulse_count - base), 32'd2);

    checkOutput("pulse_queue_drained", 32'(pulse_q.size()), 32'd0);
    checkOutput("stable_queue_drained", 32'(stable_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200us;
    fail_count++;
    $display("[TB] FAIL watchdog: simulation still running at 200 us, expected $finish earlier");
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
